// File: rtl/ecdh_job_queue.sv
// Job front-end for the ECpoint_scalar core: FIFO of (k, Px, Py), one launch at a time, k==0 short-circuit.
// Define ECDH_JOBQ_CYCCNT_EN to add the out_cycles core-latency port.
module ecdh_job_queue #(
    parameter int BW_GF = 256,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BW_GF-1:0] in_k,
    input  logic [BW_GF-1:0] in_px,
    input  logic [BW_GF-1:0] in_py,
    output logic             core_start,
    output logic [BW_GF-1:0] core_k,
    output logic [BW_GF-1:0] core_px,
    output logic [BW_GF-1:0] core_py,
    input  logic [BW_GF-1:0] core_qx,
    input  logic [BW_GF-1:0] core_qy,
    input  logic             core_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW_GF-1:0] out_qx,
    output logic [BW_GF-1:0] out_qy,
`ifdef ECDH_JOBQ_CYCCNT_EN
    output logic             out_inf,
    output logic [31:0]      out_cycles
`else
    output logic             out_inf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

    state_t           state;
    logic [BW_GF-1:0] mem_k  [DEPTH];
    logic [BW_GF-1:0] mem_px [DEPTH];
    logic [BW_GF-1:0] mem_py [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;

    // NOTE: storage arrays carry no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_k[wr_ptr]  <= in_k;
            mem_px[wr_ptr] <= in_px;
            mem_py[wr_ptr] <= in_py;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ECDH_JOBQ_CYCCNT_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cyc_next;

    assign cyc_next = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            core_start <= 1'b0;
            core_k     <= '0;
            core_px    <= '0;
            core_py    <= '0;
            out_valid  <= 1'b0;
            out_qx     <= '0;
            out_qy     <= '0;
            out_inf    <= 1'b0;
`ifdef ECDH_JOBQ_CYCCNT_EN
            cyc_cnt    <= '0;
            out_cycles <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        core_k  <= mem_k[rd_ptr];
                        core_px <= mem_px[rd_ptr];
                        core_py <= mem_py[rd_ptr];
                        if (mem_k[rd_ptr] == '0) begin
                            // k==0 yields the point at infinity without touching the core
                            out_qx    <= '0;
                            out_qy    <= '0;
                            out_inf   <= 1'b1;
                            out_valid <= 1'b1;
`ifdef ECDH_JOBQ_CYCCNT_EN
                            out_cycles <= '0;
`endif
                            state     <= DONE;
                        end else begin
                            core_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
`ifdef ECDH_JOBQ_CYCCNT_EN
                    cyc_cnt <= '0;
`endif
                    state <= BUSY;
                end
                BUSY: begin
`ifdef ECDH_JOBQ_CYCCNT_EN
                    cyc_cnt <= cyc_next;
`endif
                    if (core_valid) begin
                        out_qx    <= core_qx;
                        out_qy    <= core_qy;
                        out_inf   <= 1'b0;
                        out_valid <= 1'b1;
`ifdef ECDH_JOBQ_CYCCNT_EN
                        out_cycles <= cyc_next;
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
